pkt_store_fwd: RTL and testbench
================================

PKT_STORE_FWD -- requirements
Module: pkt_store_fwd

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving flit buffer depth 2^ADDR_W.
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_data_wr, input, 1: the flit on in_data is valid this cycle. No backpressure.
REQ-006 SHALL have port in_data, input, 134: the flit. [133:132] is the tag: 01 head, 11 body, 10 tail. [131:128] is the count of invalid bytes. [127:0] is the payload.
REQ-007 SHALL have port pktin_data_wr, output, 1: the flit on pktin_data is valid to the downstream um.
REQ-008 SHALL have port pktin_data, output, 134: the forwarded flit, in the same format as in_data.
REQ-009 SHALL have port pktin_data_valid_wr, output, 1: end-of-packet strobe.
REQ-010 SHALL have port pktin_data_valid, output, 1: packet-good flag, qualified by pktin_data_valid_wr.
REQ-011 SHALL have port pktin_ready, input, 1: um can accept a new packet.
REQ-012 SHALL have port pkt_in_cnt, output, CNT_W: number of packets accepted.
REQ-013 SHALL have port pkt_drop_cnt, output, CNT_W: number of packets dropped.

Function
REQ-014 SHALL forward only complete packets (store-and-forward). No flit of a packet leaves before its tail is committed.
REQ-015 SHALL keep three pointers, each ADDR_W+1 bits with a wrap bit: wr_ptr, commit_ptr and rd_ptr. Buffer full when wr_ptr-rd_ptr == 2^ADDR_W; read side sees data while rd_ptr != commit_ptr.
REQ-016 Write FSM SHALL have states IDLE, RECV and DROP.
REQ-017 In IDLE, a head flit SHALL be written and the FSM SHALL go to RECV. Non-head flits in IDLE SHALL be discarded silently.
REQ-018 In RECV, a body flit SHALL be written. On a tail flit the flit SHALL be written, commit_ptr SHALL be set to the new wr_ptr on the next edge, pkt_in_cnt SHALL increment, and the FSM SHALL go to IDLE.
REQ-019 In RECV, any flit arriving while the buffer is full SHALL not be written. In that case wr_ptr SHALL roll back to commit_ptr, pkt_drop_cnt SHALL increment, and the FSM SHALL go to DROP; if that flit is a tail, the FSM SHALL go to IDLE instead.
REQ-020 In RECV, a head flit (missing tail) SHALL cause a rollback to commit_ptr and pkt_drop_cnt increment. The new head SHALL then be written at commit_ptr and the FSM SHALL stay in RECV.
REQ-021 In DROP, flits SHALL be discarded until a tail, then the FSM SHALL go to IDLE. A head flit in DROP SHALL be handled as in IDLE.
REQ-022 Read FSM SHALL have states IDLE and SEND.
REQ-023 Read FSM SHALL leave IDLE only when rd_ptr != commit_ptr and pktin_ready=1.
REQ-024 Once in SEND, the read FSM SHALL emit one flit per cycle until the tail regardless of pktin_ready, then return to IDLE.
REQ-025 Read latency: a tail written at edge T SHALL allow the head to appear on pktin_data_wr at edge T+2 at the earliest, with the buffer read registered.
REQ-026 pktin_data_valid_wr and pktin_data_valid SHALL both be 1 in the same cycle as the tail flit's pktin_data_wr, and 0 otherwise.
REQ-027 Back-to-back packets SHALL leave with at most one idle cycle between a tail and the next head.
REQ-028 A write/commit and a read in the same cycle SHALL both take effect; the full check SHALL use the rd_ptr value from before that edge.
REQ-029 Counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-030 While rst=1, both FSMs SHALL be in IDLE, all pointers and counters SHALL be 0, and pktin_data_wr, pktin_data_valid_wr, pktin_data_valid and pktin_data SHALL be 0.
REQ-031 Reset mid-packet SHALL discard all buffered and partial packets. Flits of a packet already in progress at deassertion SHALL be ignored until the next head.

Structure
REQ-032 The tag encodings (TAG_HEAD=01, TAG_BODY=11, TAG_TAIL=10), the flit width 134, and the FSM state encodings SHALL live in the shared package pkt_fmt_pkg.
REQ-033 Flit storage SHALL be one sub-module, pkt_sdp_ram: a simple dual-port RAM of 2^ADDR_W x 134 with registered read, inferable as block RAM.

Verification
REQ-034 A 4-flit packet (01,11,11,10) with pktin_ready=1 SHALL produce 4 identical flits, head at tail-edge+2, valid_wr=valid=1 on the tail only, and pkt_in_cnt=1.
REQ-035 Holding pktin_ready=0 while 3 packets arrive, then releasing it, SHALL output all 3 packets in order, each unbroken, with pkt_in_cnt=3.
REQ-036 With ADDR_W=4, pktin_ready=0 and a 20-flit packet, the packet SHALL be dropped: pkt_drop_cnt=1 and no output. A following 3-flit packet SHALL then be forwarded intact.
REQ-037 Sequence head, body, head, body, tail SHALL forward only the second packet (3 flits) and set pkt_drop_cnt=1.
REQ-038 Dropping pktin_ready to 0 mid-SEND SHALL not stop output: the current packet SHALL finish, and the next packet SHALL wait until pktin_ready=1.
REQ-039 rst pulsed for 1 cycle mid-output SHALL put all outputs at 0 immediately. Body and tail flits of the interrupted input packet SHALL be ignored, and the next complete packet SHALL be forwarded.

Source files
------------

// File: rtl/pkt_fmt_pkg.sv
// Shared flit format and FSM state encodings for the store-and-forward packet buffer.
package pkt_fmt_pkg;

  localparam int FLIT_W = 134;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE = 2'b00,
    WR_RECV = 2'b01,
    WR_DROP = 2'b10
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

  function automatic logic [1:0] flit_tag(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1 -: 2];
  endfunction

endpackage

// File: rtl/pkt_sdp_ram.sv
// Simple dual-port flit RAM: one write port, one registered read port, no reset on
// storage or read data so it maps onto block RAM.
module pkt_sdp_ram
  import pkt_fmt_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = FLIT_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_store_fwd.sv
// Store-and-forward packet buffer: packets are committed only on their tail and are
// then streamed out unbroken once the downstream um signals it is ready.
module pkt_store_fwd
  import pkt_fmt_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_data_wr,
  input  logic [133:0]      in_data,
  output logic              pktin_data_wr,
  output logic [133:0]      pktin_data,
  output logic              pktin_data_valid_wr,
  output logic              pktin_data_valid,
  input  logic              pktin_ready,
  output logic [CNT_W-1:0]  pkt_in_cnt,
  output logic [CNT_W-1:0]  pkt_drop_cnt
);

  localparam logic [ADDR_W:0]  PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  FULL_DIST = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             out_wr_q, out_eop_q;
  logic [133:0]     out_data_q;

  logic              full_s, ram_we_s, ram_re_s, rd_tail_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [1:0]        in_tag_s;
  logic [133:0]      ram_rdata_s;

  assign in_tag_s  = flit_tag(in_data);
  assign full_s    = ((wr_ptr_q - rd_ptr_q) == FULL_DIST);
  assign rd_tail_s = (flit_tag(ram_rdata_s) == TAG_TAIL);

  pkt_sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(FLIT_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (in_data),
    .re_i    (ram_re_s),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata_s)
  );

  // Write FSM: accepts, rolls back or discards flits; wr_ptr == commit_ptr outside RECV.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    in_cnt_d     = in_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    ram_we_s     = 1'b0;
    ram_waddr_s  = wr_ptr_q[ADDR_W-1:0];
    if (in_data_wr) begin
      case (wr_state_q)
        WR_IDLE, WR_DROP: begin
          if (in_tag_s == TAG_HEAD) begin
            if (full_s) begin
              drop_cnt_d = drop_cnt_q + CNT_ONE;
              wr_state_d = WR_DROP;
            end else begin
              ram_we_s   = 1'b1;
              wr_ptr_d   = wr_ptr_q + PTR_ONE;
              wr_state_d = WR_RECV;
            end
          end else if ((wr_state_q == WR_DROP) && (in_tag_s == TAG_TAIL)) begin
            wr_state_d = WR_IDLE;
          end else begin
            wr_state_d = wr_state_q;
          end
        end
        WR_RECV: begin
          if (full_s) begin
            wr_ptr_d   = commit_ptr_q;
            drop_cnt_d = drop_cnt_q + CNT_ONE;
            wr_state_d = (in_tag_s == TAG_TAIL) ? WR_IDLE : WR_DROP;
          end else if (in_tag_s == TAG_HEAD) begin
            // Missing tail: abandon the partial packet and restart at the commit point.
            drop_cnt_d  = drop_cnt_q + CNT_ONE;
            ram_we_s    = 1'b1;
            ram_waddr_s = commit_ptr_q[ADDR_W-1:0];
            wr_ptr_d    = commit_ptr_q + PTR_ONE;
          end else if (in_tag_s == TAG_BODY) begin
            ram_we_s = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end else if (in_tag_s == TAG_TAIL) begin
            ram_we_s     = 1'b1;
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            in_cnt_d     = in_cnt_q + CNT_ONE;
            wr_state_d   = WR_IDLE;
          end else begin
            wr_state_d = WR_RECV;
          end
        end
        default: begin
          wr_state_d = WR_IDLE;
        end
      endcase
    end else begin
      wr_state_d = wr_state_q;
    end
  end

  // Read FSM: a read issued in SEND is always followed by one in the next cycle until
  // the tail shows up on the RAM output, so reads never run past the packet end.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    ram_re_s   = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if ((rd_ptr_q != commit_ptr_q) && pktin_ready) begin
          ram_re_s   = 1'b1;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          rd_state_d = RD_SEND;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_SEND: begin
        if (rd_tail_s) begin
          rd_state_d = RD_IDLE;
        end else begin
          ram_re_s = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q   <= WR_IDLE;
      rd_state_q   <= RD_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      in_cnt_q     <= '0;
      drop_cnt_q   <= '0;
      out_wr_q     <= 1'b0;
      out_eop_q    <= 1'b0;
      out_data_q   <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_cnt_q     <= in_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      out_wr_q     <= (rd_state_q == RD_SEND);
      out_eop_q    <= (rd_state_q == RD_SEND) && rd_tail_s;
      out_data_q   <= (rd_state_q == RD_SEND) ? ram_rdata_s : '0;
    end
  end

  assign pktin_data_wr       = out_wr_q;
  assign pktin_data          = out_data_q;
  assign pktin_data_valid_wr = out_eop_q;
  assign pktin_data_valid    = out_eop_q;
  assign pkt_in_cnt          = in_cnt_q;
  assign pkt_drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_pkt_store_fwd.sv
// Scoreboard bench for pkt_store_fwd: expected flits are queued as packets are driven
// and compared flit by flit as they leave the buffer.
module tb_pkt_store_fwd;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b11;
  localparam logic [1:0] T_TAIL = 2'b10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_data_wr;
  logic [133:0] in_data;
  logic         pktin_data_wr;
  logic [133:0] pktin_data;
  logic         pktin_data_valid_wr;
  logic         pktin_data_valid;
  logic         pktin_ready;
  logic [31:0]  pkt_in_cnt;
  logic [31:0]  pkt_drop_cnt;

  pkt_store_fwd #(.ADDR_W(4), .CNT_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_data_wr          (in_data_wr),
    .in_data             (in_data),
    .pktin_data_wr       (pktin_data_wr),
    .pktin_data          (pktin_data),
    .pktin_data_valid_wr (pktin_data_valid_wr),
    .pktin_data_valid    (pktin_data_valid),
    .pktin_ready         (pktin_ready),
    .pkt_in_cnt          (pkt_in_cnt),
    .pkt_drop_cnt        (pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tail_in_cyc = 0;
  int head_cyc = 0;
  int last_tail_cyc = 0;
  bit b2b_en = 1'b0;
  bit b2b_seen = 1'b0;
  bit in_pkt = 1'b0;
  int exp_in = 0;
  int exp_drop = 0;
  logic [133:0] sb[$];
  logic [133:0] mon_exp;
  logic         mon_tail;

  task automatic check_eq(input string name, input logic [133:0] got, input logic [133:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every forwarded flit.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 1'b0;
    end else begin
      if (in_pkt) check_eq("unbroken", pktin_data_wr, 1);
      if (pktin_data_wr) begin
        check_eq("sb_avail", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_exp  = sb.pop_front();
          mon_tail = (mon_exp[133:132] == T_TAIL);
          check_eq("flit", pktin_data, mon_exp);
          check_eq("valid_wr", pktin_data_valid_wr, mon_tail);
          check_eq("valid", pktin_data_valid, mon_tail);
          if (mon_exp[133:132] == T_HEAD) begin
            head_cyc = cyc;
            if (b2b_en && b2b_seen) check_eq("b2b_gap", ((cyc - last_tail_cyc) <= 2), 1);
          end
          if (mon_tail) begin
            last_tail_cyc = cyc;
            b2b_seen = b2b_en;
          end
        end
        in_pkt = (pktin_data[133:132] != T_TAIL);
      end else begin
        check_eq("idle_valid_wr", pktin_data_valid_wr, 0);
        check_eq("idle_valid", pktin_data_valid, 0);
      end
    end
  end

  task automatic send_flit(input logic [1:0] tag, input int id, input int idx, input bit expect_out);
    logic [133:0] f;
    @(negedge clk);
    f = {tag, (tag == T_TAIL) ? 4'd3 : 4'd0, 32'(id), 32'(idx), 64'h0123_4567_89AB_CDEF};
    in_data_wr = 1'b1;
    in_data    = f;
    if (tag == T_TAIL) tail_in_cyc = cyc;
    if (expect_out) sb.push_back(f);
  endtask

  task automatic send_pkt(input int n, input int id, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      send_flit((i == 0) ? T_HEAD : ((i == n - 1) ? T_TAIL : T_BODY), id, i, expect_out);
    end
  endtask

  task automatic stop_in();
    @(negedge clk);
    in_data_wr = 1'b0;
    in_data    = '0;
  endtask

  task automatic hold_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("hold", pktin_data_wr, 0);
    end
  endtask

  task automatic wait_sb(input int left, input int budget);
    int k = 0;
    while (sb.size() > left && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check_eq("sb_level", sb.size(), left);
  endtask

  task automatic check_cnts(input string name);
    check_eq({name, "_in_cnt"}, pkt_in_cnt, exp_in);
    check_eq({name, "_drop_cnt"}, pkt_drop_cnt, exp_drop);
  endtask

  initial begin
    rst = 1'b1;
    in_data_wr = 1'b0;
    in_data = '0;
    pktin_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wr", pktin_data_wr, 0);
    check_eq("rst_data", pktin_data, 0);
    check_eq("rst_valid_wr", pktin_data_valid_wr, 0);
    check_eq("rst_valid", pktin_data_valid, 0);
    check_cnts("rst");
    @(negedge clk);
    rst = 1'b0;

    // Single 4-flit packet, latency from tail edge to head.
    pktin_ready = 1'b1;
    send_pkt(4, 1, 1'b1);
    stop_in();
    exp_in++;
    wait_sb(0, 40);
    check_eq("latency", head_cyc - tail_in_cyc, 3);
    check_cnts("one_pkt");

    // Three packets held back, then released back to back.
    pktin_ready = 1'b0;
    send_pkt(2, 2, 1'b1);
    send_pkt(3, 3, 1'b1);
    send_pkt(4, 4, 1'b1);
    stop_in();
    exp_in += 3;
    hold_check(5);
    b2b_en = 1'b1;
    pktin_ready = 1'b1;
    wait_sb(0, 60);
    b2b_en = 1'b0;
    b2b_seen = 1'b0;
    check_cnts("three_pkt");

    // Oversized packet overflows the 16-entry buffer and is dropped.
    pktin_ready = 1'b0;
    send_pkt(20, 5, 1'b0);
    stop_in();
    exp_drop++;
    hold_check(4);
    check_cnts("overflow");
    send_pkt(3, 6, 1'b1);
    stop_in();
    exp_in++;
    hold_check(3);
    pktin_ready = 1'b1;
    wait_sb(0, 40);
    check_cnts("after_overflow");

    // Head without tail: first packet dropped, second forwarded.
    send_flit(T_HEAD, 7, 0, 1'b0);
    send_flit(T_BODY, 7, 1, 1'b0);
    send_flit(T_HEAD, 8, 0, 1'b1);
    send_flit(T_BODY, 8, 1, 1'b1);
    send_flit(T_TAIL, 8, 2, 1'b1);
    stop_in();
    exp_in++;
    exp_drop++;
    wait_sb(0, 40);
    check_cnts("missing_tail");

    // Ready drops mid-send: current packet completes, next one waits.
    send_pkt(6, 9, 1'b1);
    send_pkt(3, 10, 1'b1);
    pktin_ready = 1'b0;
    stop_in();
    exp_in += 2;
    wait_sb(3, 40);
    hold_check(6);
    pktin_ready = 1'b1;
    wait_sb(0, 40);
    check_cnts("ready_drop");

    // Reset pulse while a packet is being output and another is arriving.
    send_pkt(6, 11, 1'b1);
    send_flit(T_HEAD, 12, 0, 1'b0);
    send_flit(T_BODY, 12, 1, 1'b0);
    @(posedge clk);
    #1;
    check_eq("pre_rst_active", pktin_data_wr, 1);
    #1;
    rst = 1'b1;
    in_data_wr = 1'b0;
    sb.delete();
    exp_in = 0;
    exp_drop = 0;
    #1;
    check_eq("midrst_wr", pktin_data_wr, 0);
    check_eq("midrst_data", pktin_data, 0);
    check_eq("midrst_valid_wr", pktin_data_valid_wr, 0);
    check_eq("midrst_valid", pktin_data_valid, 0);
    check_cnts("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_flit(T_BODY, 12, 2, 1'b0);
    send_flit(T_TAIL, 12, 3, 1'b0);
    send_pkt(3, 13, 1'b1);
    stop_in();
    exp_in++;
    wait_sb(0, 40);
    check_cnts("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
